// File: rtl/dehaze_pkg.sv
// Shared definitions for the dehaze pipeline stages: default pixel width and
// the pixel-counter width helper used by the frame-level blocks.
package dehaze_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    function automatic int pix_cnt_w(input int img_w, input int img_h);
        int n;
        n = img_w * img_h;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iir_ch.sv
// One colour channel of the atmospheric-light register: direct load on the
// first update after reset, first-order IIR smoothing afterwards.
module iir_ch #(
    parameter int DATA_WIDTH   = 8,
    parameter int SMOOTH_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  update,
    input  logic                  init,
    input  logic [DATA_WIDTH-1:0] f,
    output logic [DATA_WIDTH-1:0] a
);

    logic [DATA_WIDTH-1:0]        a_q;
    logic [DATA_WIDTH-1:0]        a_d;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [DATA_WIDTH:0]   step;
    logic signed [DATA_WIDTH:0]   sum;

    // Arithmetic shift floors the step; the sum stays between old A and f.
    always_comb begin
        diff = $signed({1'b0, f}) - $signed({1'b0, a_q});
        step = diff >>> SMOOTH_SHIFT;
        sum  = $signed({1'b0, a_q}) + step;
        a_d  = a_q;
        if (update) begin
            if (!init || (SMOOTH_SHIFT == 0)) begin
                a_d = f;
            end else begin
                a_d = DATA_WIDTH'(sum);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
        end else begin
            a_q <= a_d;
        end
    end

    assign a = a_q;

endmodule

// File: rtl/atmos_light_est.sv
// Frame-level atmospheric-light estimator: tracks the brightest dark-channel
// pixel per frame and folds its RGB into a smoothed A at frame end.
module atmos_light_est
    import dehaze_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH    = 320,
    parameter int IMG_HEIGHT   = 240,
    parameter int SMOOTH_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic                  sof_in,
    input  logic [DATA_WIDTH-1:0] dark_in,
    input  logic [DATA_WIDTH-1:0] r_in,
    input  logic [DATA_WIDTH-1:0] g_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  a_valid,
    output logic [DATA_WIDTH-1:0] a_r,
    output logic [DATA_WIDTH-1:0] a_g,
    output logic [DATA_WIDTH-1:0] a_b,
    output logic [DATA_WIDTH-1:0] a_dark
);

    localparam int               PIX_N    = IMG_WIDTH * IMG_HEIGHT;
    localparam int               CNT_W    = pix_cnt_w(IMG_WIDTH, IMG_HEIGHT);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_N - 1);

    logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]      cur_idx;
    logic [DATA_WIDTH-1:0] max_dark_q, max_dark_d;
    logic [DATA_WIDTH-1:0] cap_r_q, cap_r_d;
    logic [DATA_WIDTH-1:0] cap_g_q, cap_g_d;
    logic [DATA_WIDTH-1:0] cap_b_q, cap_b_d;
    logic                  frame_done_q, frame_done_d;
    logic                  a_valid_q, a_valid_d;
    logic [DATA_WIDTH-1:0] a_dark_q, a_dark_d;
    logic                  init_q, init_d;
    logic                  load_px;

    // A sof pixel is always index 0 and can never close the frame it opens.
    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        max_dark_d   = max_dark_q;
        cap_r_d      = cap_r_q;
        cap_g_d      = cap_g_q;
        cap_b_d      = cap_b_q;
        frame_done_d = 1'b0;
        cur_idx      = sof_in ? '0 : pix_cnt_q;
        load_px      = 1'b0;
        if (valid_in) begin
            load_px = (cur_idx == '0) || (dark_in > max_dark_q);
            if (load_px) begin
                max_dark_d = dark_in;
                cap_r_d    = r_in;
                cap_g_d    = g_in;
                cap_b_d    = b_in;
            end
            if (cur_idx == LAST_PIX) begin
                pix_cnt_d    = '0;
                frame_done_d = !sof_in;
            end else begin
                pix_cnt_d = cur_idx + CNT_W'(1);
            end
        end
    end

    // Second stage reads the tracker before a following pixel 0 overwrites it.
    always_comb begin
        a_valid_d = frame_done_q;
        a_dark_d  = a_dark_q;
        init_d    = init_q;
        if (frame_done_q) begin
            a_dark_d = max_dark_q;
            init_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q    <= '0;
            max_dark_q   <= '0;
            cap_r_q      <= '0;
            cap_g_q      <= '0;
            cap_b_q      <= '0;
            frame_done_q <= 1'b0;
            a_valid_q    <= 1'b0;
            a_dark_q     <= '0;
            init_q       <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            max_dark_q   <= max_dark_d;
            cap_r_q      <= cap_r_d;
            cap_g_q      <= cap_g_d;
            cap_b_q      <= cap_b_d;
            frame_done_q <= frame_done_d;
            a_valid_q    <= a_valid_d;
            a_dark_q     <= a_dark_d;
            init_q       <= init_d;
        end
    end

    iir_ch #(.DATA_WIDTH(DATA_WIDTH), .SMOOTH_SHIFT(SMOOTH_SHIFT)) u_iir_r (
        .clk(clk), .rst_n(rst_n), .update(frame_done_q), .init(init_q),
        .f(cap_r_q), .a(a_r)
    );

    iir_ch #(.DATA_WIDTH(DATA_WIDTH), .SMOOTH_SHIFT(SMOOTH_SHIFT)) u_iir_g (
        .clk(clk), .rst_n(rst_n), .update(frame_done_q), .init(init_q),
        .f(cap_g_q), .a(a_g)
    );

    iir_ch #(.DATA_WIDTH(DATA_WIDTH), .SMOOTH_SHIFT(SMOOTH_SHIFT)) u_iir_b (
        .clk(clk), .rst_n(rst_n), .update(frame_done_q), .init(init_q),
        .f(cap_b_q), .a(a_b)
    );

    assign a_valid = a_valid_q;
    assign a_dark  = a_dark_q;

endmodule

// File: tb/tb_atmos_light_est.sv
// Directed bench for atmos_light_est on a 4x2 image with k=2; every a_valid
// pulse is logged as {a_r,a_g,a_b,a_dark} and compared to hand-computed values.
module tb_atmos_light_est;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic       sof_in;
    logic [7:0] dark_in;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic       a_valid;
    logic [7:0] a_r;
    logic [7:0] a_g;
    logic [7:0] a_b;
    logic [7:0] a_dark;

    int errors;
    int checks;
    logic [31:0] mon_q[$];

    atmos_light_est #(
        .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2), .SMOOTH_SHIFT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in),
        .dark_in(dark_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .a_valid(a_valid), .a_r(a_r), .a_g(a_g), .a_b(a_b), .a_dark(a_dark)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_valid === 1'b1) mon_q.push_back({a_r, a_g, a_b, a_dark});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            sof_in   = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        valid_in = 1'b0;
        sof_in   = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_px(input logic [7:0] d, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b,
                           input logic sof, input bit gaps);
        if (gaps) idle($urandom_range(0, 3));
        @(negedge clk);
        valid_in = 1'b1;
        sof_in   = sof;
        dark_in  = d;
        r_in     = r;
        g_in     = g;
        b_in     = b;
    endtask

    // Fillers have low dark values and bright, wrong RGB to expose bad captures.
    task automatic send_frame(input int max_idx, input logic [7:0] mdark,
                              input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic sof, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (i == max_idx)
                send_px(mdark, r, g, b, sof && (i == 0), gaps);
            else
                send_px(8'(2 + (i * 3) % 16), 8'(250 - i), 8'(240 - i), 8'(230 - i),
                        sof && (i == 0), gaps);
        end
    endtask

    task automatic test_reset();
        mon_q.delete();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(10);
        checks++;
        if (mon_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_pulse: pulses=%0d expected 0", mon_q.size());
        end
        checks++;
        if ({a_valid, a_r, a_g, a_b, a_dark} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {a_valid, a_r, a_g, a_b, a_dark});
        end
    endtask

    task automatic test_first_frame();
        logic [7:0] darks [8];
        darks = '{10, 50, 30, 50, 20, 5, 5, 5};
        mon_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (i == 1)      send_px(darks[i], 200, 180, 160, 1'b0, 1'b0);
            else if (i == 3) send_px(darks[i], 11, 22, 33, 1'b0, 1'b0);
            else             send_px(darks[i], 8'(i * 7), 8'(i * 9), 8'(i * 5), i == 0, 1'b0);
        end
        @(negedge clk);
        valid_in = 1'b0;
        sof_in   = 1'b0;
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: a_valid=%b expected 0", a_valid);
        end
        @(negedge clk);
        checks++;
        if (a_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_pulse: a_valid=%b expected 1", a_valid);
        end
        checks++;
        if ({a_r, a_g, a_b, a_dark} !== {8'd200, 8'd180, 8'd160, 8'd50}) begin
            errors++;
            $display("FAIL first_load: got %h expected %h", {a_r, a_g, a_b, a_dark},
                     {8'd200, 8'd180, 8'd160, 8'd50});
        end
        @(negedge clk);
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: a_valid=%b expected 0", a_valid);
        end
        idle(3);
        checks++;
        if (mon_q.size() !== 1) begin
            errors++;
            $display("FAIL first_pulse_count: pulses=%0d expected 1", mon_q.size());
        end
        checks++;
        if ({a_r, a_g, a_b, a_dark} !== {8'd200, 8'd180, 8'd160, 8'd50}) begin
            errors++;
            $display("FAIL first_hold: got %h expected %h", {a_r, a_g, a_b, a_dark},
                     {8'd200, 8'd180, 8'd160, 8'd50});
        end
    endtask

    // 200->175, 180->160, 160->145; then floor rounding 175->156, 160->145, 145->133.
    task automatic test_smoothing();
        logic [31:0] exp [2];
        exp = '{{8'd175, 8'd160, 8'd145, 8'd90}, {8'd156, 8'd145, 8'd133, 8'd90}};
        mon_q.delete();
        send_frame(5, 90, 100, 100, 100, 1'b1, 1'b0);
        send_frame(5, 90, 100, 100, 100, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (mon_q.size() !== 2) begin
            errors++;
            $display("FAIL smooth_count: pulses=%0d expected 2", mon_q.size());
        end
        for (int i = 0; i < 2 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL smooth_%0d: got %h expected %h", i, mon_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_gaps();
        for (int g = 0; g < 2; g++) begin
            apply_reset();
            mon_q.delete();
            send_frame(2, 60, 100, 100, 100, 1'b1, g == 1);
            send_frame(6, 60, 200, 200, 200, 1'b1, g == 1);
            idle(4);
            checks++;
            if (mon_q.size() !== 2) begin
                errors++;
                $display("FAIL gaps%0d_count: pulses=%0d expected 2", g, mon_q.size());
            end else begin
                checks++;
                if (mon_q[1] !== {8'd125, 8'd125, 8'd125, 8'd60}) begin
                    errors++;
                    $display("FAIL gaps%0d_iir: got %h expected %h", g, mon_q[1],
                             {8'd125, 8'd125, 8'd125, 8'd60});
                end
            end
        end
    endtask

    // Second frame follows with no sof and no bubble: 80->60, 80->70, 80->90.
    task automatic test_back_to_back();
        apply_reset();
        mon_q.delete();
        send_frame(7, 40, 80, 80, 80, 1'b1, 1'b0);
        send_frame(0, 99, 0, 40, 120, 1'b0, 1'b0);
        idle(4);
        checks++;
        if (mon_q.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count: pulses=%0d expected 2", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0] !== {8'd80, 8'd80, 8'd80, 8'd40}) begin
                errors++;
                $display("FAIL b2b_first: got %h expected %h", mon_q[0], {8'd80, 8'd80, 8'd80, 8'd40});
            end
            checks++;
            if (mon_q[1] !== {8'd60, 8'd70, 8'd90, 8'd99}) begin
                errors++;
                $display("FAIL b2b_second: got %h expected %h", mon_q[1], {8'd60, 8'd70, 8'd90, 8'd99});
            end
        end
    endtask

    // sof at pixel 3, then sof landing on the last-pixel slot: 30->50, 60->60, 90->70.
    task automatic test_sof_abort();
        apply_reset();
        mon_q.delete();
        for (int i = 0; i < 3; i++) send_px(255, 9, 9, 9, i == 0, 1'b0);
        send_frame(2, 70, 30, 60, 90, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send_px(250, 250, 250, 250, i == 0, 1'b0);
        send_frame(4, 110, 110, 60, 10, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (mon_q.size() !== 2) begin
            errors++;
            $display("FAIL sof_count: pulses=%0d expected 2", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0] !== {8'd30, 8'd60, 8'd90, 8'd70}) begin
                errors++;
                $display("FAIL sof_mid: got %h expected %h", mon_q[0], {8'd30, 8'd60, 8'd90, 8'd70});
            end
            checks++;
            if (mon_q[1] !== {8'd50, 8'd60, 8'd70, 8'd110}) begin
                errors++;
                $display("FAIL sof_last: got %h expected %h", mon_q[1], {8'd50, 8'd60, 8'd70, 8'd110});
            end
        end
    endtask

    task automatic test_reset_mid();
        mon_q.delete();
        for (int i = 0; i < 5; i++) send_px(200, 200, 200, 200, i == 0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_valid, a_r, a_g, a_b, a_dark} !== 33'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", {a_valid, a_r, a_g, a_b, a_dark});
        end
        idle(2);
        rst_n = 1'b1;
        send_frame(3, 33, 40, 40, 40, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (mon_q.size() !== 1) begin
            errors++;
            $display("FAIL rstmid_count: pulses=%0d expected 1", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0] !== {8'd40, 8'd40, 8'd40, 8'd33}) begin
                errors++;
                $display("FAIL rstmid_load: got %h expected %h", mon_q[0], {8'd40, 8'd40, 8'd40, 8'd33});
            end
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        dark_in  = '0;
        r_in     = '0;
        g_in     = '0;
        b_in     = '0;
        test_reset();
        test_first_frame();
        test_smoothing();
        test_gaps();
        test_back_to_back();
        test_sof_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
